softmax_argmax_ctrl: RTL and testbench
======================================

// Module: softmax_argmax_ctrl
// PURPOSE
//  Initiator/consumer for the softmax layer: drives its enb line, waits for its ack, snapshots the
//  INPUT_NUM float32 probabilities and serially scans them for the largest one. Sits after softmax
//  at the end of the CNN datapath and returns the winning class index and its probability to the
//  top-level controller over a valid/ready result interface.
// PARAMETERS
//  DATA_WIDTH   32     float word width; IEEE-754 single only (other values unsupported)
//  INPUT_NUM    10     number of classes on the probability bus
//  IDX_W        4      class index width; 2**IDX_W >= INPUT_NUM
//  TIMEOUT_CYC  4096   max cycles waiting for softmax ack before aborting
// PORTS
//  clk         in   1                     single clock, all state on posedge
//  rst         in   1                     asynchronous, active-high reset
//  start       in   1                     1-cycle request to classify; honoured only in IDLE
//  soft_enb    out  1                     enable to softmax (its enb input)
//  soft_ack    in   1                     softmax done (its ackSoft output)
//  soft_data   in   DATA_WIDTH*INPUT_NUM  softmax outputs, word i at [DATA_WIDTH*i +: DATA_WIDTH]
//  busy        out  1                     high in any state except IDLE
//  res_valid   out  1                     result available
//  res_ready   in   1                     consumer accepts result
//  res_idx     out  IDX_W                 index of max probability
//  res_prob    out  DATA_WIDTH            max probability value
//  res_timeout out  1                     1 = result aborted by timeout (idx/prob invalid)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; soft_enb=0, busy=0, res_valid=0, res_idx=0,
//    res_prob=0, res_timeout=0; counters and snapshot cleared. Reset mid-operation drops soft_enb
//    at once, returning softmax to its own cleared state.
//  - FSM IDLE -> WAIT_ACK -> SCAN -> DONE -> IDLE:
//    IDLE: start=1 -> WAIT_ACK, soft_enb<=1, timeout counter<=0. start in other states ignored.
//    WAIT_ACK: soft_ack sampled on posedge. ack=1 -> copy soft_data to snapshot register,
//      soft_enb<=0, scan idx<=0, best<=word0 (initial), -> SCAN. Else counter++; counter reaching
//      TIMEOUT_CYC-1 -> soft_enb<=0, res_timeout<=1, -> DONE.
//    SCAN: one word per cycle, i=1..INPUT_NUM-1 from the snapshot (not the live bus);
//      if word_i > best strictly then best<=word_i, best_idx<=i. Ties keep the lower index.
//      After i=INPUT_NUM-1 -> DONE with res_idx/res_prob loaded, res_timeout<=0.
//    DONE: res_valid=1; outputs stable while res_valid=1 and res_ready=0. res_ready=1 -> IDLE,
//      res_valid<=0 next cycle. start coincident with res_ready in DONE is ignored.
//  - Latency: start edge to soft_enb high = 1 cycle; ack seen to res_valid = INPUT_NUM cycles.
//  - soft_enb is low for >=1 full cycle between requests (IDLE/DONE), guaranteeing softmax
//    reinitialises its counters on its negedge reset path before the next enable.
//  - Float compare (total order): NaN (exp=all 1s, mant!=0) is less than every non-NaN; two NaNs
//    equal. +0 == -0. Otherwise sign-magnitude: positive > negative; positives ordered by
//    {exp,mant} ascending, negatives descending. +Inf is the largest non-NaN.
//  - Snapshot ensures softmax may clear outputs after soft_enb drops without corrupting scan.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/WAIT_ACK/SCAN/DONE), IEEE-754 field constants
//    (EXP_W=8, MANT_W=23, EXP_ALL1), INPUT_NUM default.
//  - One sub-module: float_cmp_gt (combinational, a>b per total order above), instanced once.
//  - Top: FSM, timeout counter, scan counter, snapshot register, best/best_idx registers.
// TESTING
//  1 Probabilities 0.01 x9 with word6=0.91 (0x3F68F5C3); ack 5 cycles after enb -> res_idx=6,
//    res_prob=0x3F68F5C3, res_valid exactly 10 cycles after ack sampled, soft_enb low after ack.
//  2 Tie: words 2 and 7 both 0x3F000000, rest 0 -> res_idx=2.
//  3 Compare corners: word0=NaN 0x7FC00000, word1=-1.0, word3=+Inf, word4=-0, rest +0
//    -> res_idx=3, res_prob=0x7F800000; float_cmp_gt unit check +0 vs -0 -> not greater.
//  4 No ack: TIMEOUT_CYC=16, soft_ack held 0 -> soft_enb drops after 16 cycles, res_valid=1,
//    res_timeout=1; next run with valid ack clears res_timeout.
//  5 Backpressure: res_ready low 20 cycles in DONE, start pulsed meanwhile -> outputs stable,
//    start ignored, busy=1; res_ready=1 -> IDLE, next start accepted.
//  6 rst asserted mid-SCAN (asynchronously, between edges) -> soft_enb, busy, res_valid low
//    immediately; post-reset start runs a full correct classification.

Source files
------------

// File: rtl/softmax_argmax_ctrl_pkg.sv
// Shared definitions for the softmax argmax controller.
// Holds the FSM state encoding, the IEEE-754 single-precision field layout and the default class count.
// No logic, so no latency or backpressure of its own.
package softmax_argmax_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_SCAN     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int         EXP_W         = 8;
  localparam int         MANT_W        = 23;
  localparam int         FLOAT_W       = 1 + EXP_W + MANT_W;
  localparam logic [7:0] EXP_ALL1      = 8'hFF;
  localparam int         INPUT_NUM_DEF = 10;

endpackage

// File: rtl/softmax_argmax_ctrl_float_cmp_gt.sv
// float_cmp_gt: combinational a > b over float32 using a total order.
// Ports: a_i, b_i (float32 operands), gt_o (1 when a is strictly greater than b).
// Latency: 0 cycles. Backpressure: none (pure logic).
// Ordering: every NaN sits below every number and equals other NaNs; +0 and -0 are equal;
// everything else follows sign-magnitude order, so +Inf is the largest non-NaN.
module float_cmp_gt
  import softmax_argmax_ctrl_pkg::*;
(
  input  logic [FLOAT_W-1:0] a_i,
  input  logic [FLOAT_W-1:0] b_i,
  output logic               gt_o
);

  logic                      a_sign, b_sign;
  logic [EXP_W+MANT_W-1:0]   a_mag, b_mag;
  logic                      a_nan, b_nan;

  assign a_sign = a_i[FLOAT_W-1];
  assign b_sign = b_i[FLOAT_W-1];
  assign a_mag  = a_i[EXP_W+MANT_W-1:0];
  assign b_mag  = b_i[EXP_W+MANT_W-1:0];
  assign a_nan  = (a_i[EXP_W+MANT_W-1:MANT_W] == EXP_ALL1) && (a_i[MANT_W-1:0] != '0);
  assign b_nan  = (b_i[EXP_W+MANT_W-1:MANT_W] == EXP_ALL1) && (b_i[MANT_W-1:0] != '0);

  always_comb begin
    gt_o = 1'b0;
    if (a_nan) begin
      gt_o = 1'b0;
    end else if (b_nan) begin
      gt_o = 1'b1;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      // +0 and -0 compare equal regardless of sign bits
      gt_o = 1'b0;
    end else if (a_sign != b_sign) begin
      // at most one operand is a zero here, so the sign alone decides
      gt_o = ~a_sign;
    end else if (!a_sign) begin
      gt_o = (a_mag > b_mag);
    end else begin
      gt_o = (a_mag < b_mag);
    end
  end

endmodule

// File: rtl/softmax_argmax_ctrl.sv
// softmax_argmax_ctrl: requests softmax, snapshots its INPUT_NUM float32 outputs, scans for the max.
// Ports: start/busy (request), soft_enb/soft_ack/soft_data (softmax side),
//   res_valid/res_ready/res_idx/res_prob/res_timeout (result side).
// Latency: start -> soft_enb 1 cycle; ack sampled -> res_valid INPUT_NUM cycles.
// Backpressure: the result is held stable in DONE until res_ready; start is ignored outside IDLE.
module softmax_argmax_ctrl
  import softmax_argmax_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_NUM   = INPUT_NUM_DEF,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            soft_enb,
  input  logic                            soft_ack,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0] soft_data,
  output logic                            busy,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [IDX_W-1:0]                res_idx,
  output logic [DATA_WIDTH-1:0]           res_prob,
  output logic                            res_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                          state_q, state_d;
  logic                            enb_q, enb_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [DATA_WIDTH-1:0]           best_q, best_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                res_idx_q, res_idx_d;
  logic [DATA_WIDTH-1:0]           res_prob_q, res_prob_d;
  logic                            res_to_q, res_to_d;
  logic [DATA_WIDTH*INPUT_NUM-1:0] snap_q;
  logic                            snap_we;
  logic [DATA_WIDTH-1:0]           cur_word;
  logic                            cur_gt;

  // The scan reads the snapshot, so softmax may clear its outputs once enb drops.
  assign cur_word = snap_q[DATA_WIDTH*int'(idx_q) +: DATA_WIDTH];

  float_cmp_gt u_cmp (
    .a_i  (cur_word),
    .b_i  (best_q),
    .gt_o (cur_gt)
  );

  always_comb begin
    state_d    = state_q;
    enb_d      = enb_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    res_idx_d  = res_idx_q;
    res_prob_d = res_prob_q;
    res_to_d   = res_to_q;
    snap_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_ACK;
          enb_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (soft_ack) begin
          snap_we    = 1'b1;
          enb_d      = 1'b0;
          idx_d      = '0;
          best_d     = soft_data[DATA_WIDTH-1:0];
          best_idx_d = '0;
          state_d    = ST_SCAN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          enb_d      = 1'b0;
          res_to_d   = 1'b1;
          res_idx_d  = '0;
          res_prob_d = '0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        // Scan starts at word 0 (a no-op against itself) so ack-to-valid is INPUT_NUM cycles.
        // Strict compare keeps the lower index on ties.
        if (cur_gt) begin
          best_d     = cur_word;
          best_idx_d = idx_q;
        end
        if (idx_q == IDX_W'(INPUT_NUM - 1)) begin
          res_idx_d  = cur_gt ? idx_q : best_idx_q;
          res_prob_d = cur_gt ? cur_word : best_q;
          res_to_d   = 1'b0;
          state_d    = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enb_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      res_idx_q  <= '0;
      res_prob_q <= '0;
      res_to_q   <= 1'b0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      enb_q      <= enb_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      res_idx_q  <= res_idx_d;
      res_prob_q <= res_prob_d;
      res_to_q   <= res_to_d;
      if (snap_we) begin
        snap_q <= soft_data;
      end
    end
  end

  assign soft_enb    = enb_q;
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign res_idx     = res_idx_q;
  assign res_prob    = res_prob_q;
  assign res_timeout = res_to_q;

endmodule

// File: tb/tb_softmax_argmax_ctrl.sv
// Bench for softmax_argmax_ctrl: table of classification vectors, float compare unit table,
// and hand-written sequences for timeout, backpressure and asynchronous reset.
module tb_softmax_argmax_ctrl;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              soft_ack = 1'b0;
  logic              res_ready = 1'b0;
  logic [DW*N-1:0]   soft_data = '0;
  logic              soft_enb, busy, res_valid, res_timeout;
  logic [IW-1:0]     res_idx;
  logic [DW-1:0]     res_prob;

  logic [31:0]       ca, cb;
  logic              cgt;

  always #5 clk = ~clk;

  softmax_argmax_ctrl #(
    .DATA_WIDTH (DW),
    .INPUT_NUM  (N),
    .IDX_W      (IW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .soft_enb   (soft_enb),
    .soft_ack   (soft_ack),
    .soft_data  (soft_data),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_idx    (res_idx),
    .res_prob   (res_prob),
    .res_timeout(res_timeout)
  );

  float_cmp_gt u_cmp_ref (
    .a_i  (ca),
    .b_i  (cb),
    .gt_o (cgt)
  );

  typedef struct {
    logic [N-1:0][31:0] w;
    int                 ack_dly;
    logic [IW-1:0]      idx;
    logic [31:0]        prob;
  } vec_t;

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   prob;
    logic          to;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        gt;
  } cvec_t;

  int    checks = 0;
  int    failures = 0;
  exp_t  sbq[$];
  vec_t  vecs[6];
  cvec_t cv[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic pop_check(input string tag, output exp_t e);
    e = '{idx: '0, prob: '0, to: 1'b0};
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check({tag, "_timeout"}, 32'(res_timeout), 32'(e.to));
      if (!e.to) begin
        check({tag, "_idx"}, 32'(res_idx), 32'(e.idx));
        check({tag, "_prob"}, res_prob, e.prob);
      end
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!res_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) check({tag, "_valid_timeout"}, 32'(res_valid), 32'd1);
  endtask

  // One full classification; hold>0 keeps res_ready low that many cycles while pulsing start.
  task automatic run_vec(input vec_t v, input string tag, input int hold);
    exp_t e;
    int   n;
    int   bad;
    sbq.push_back('{idx: v.idx, prob: v.prob, to: 1'b0});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_enb_up"}, 32'(soft_enb), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (v.ack_dly) @(posedge clk);
    #1;
    soft_ack  = 1'b1;
    soft_data = v.w;
    @(posedge clk); #1;
    soft_ack  = 1'b0;
    // Live bus now shows +Inf everywhere; a scan of the live bus would pick a wrong result.
    soft_data = {N{32'h7F800000}};
    check({tag, "_enb_down"}, 32'(soft_enb), 32'd0);
    wait_valid(tag, n);
    check({tag, "_latency"}, 32'(n), 32'(N));
    pop_check(tag, e);
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      start = (k % 3 == 0);
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || busy !== 1'b1 || soft_enb !== 1'b0 ||
          res_idx !== e.idx || res_prob !== e.prob || res_timeout !== 1'b0) bad++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, 32'(bad), 32'd0);
    // start coincident with res_ready must be ignored
    start     = (hold > 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_accept_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_accept_busy"}, 32'(busy), 32'd0);
    if (hold > 0) check({tag, "_accept_enb"}, 32'(soft_enb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;

    vecs[0].w = {N{32'h3C23D70A}}; vecs[0].w[6] = 32'h3F68F5C3;
    vecs[0].ack_dly = 5; vecs[0].idx = 4'd6; vecs[0].prob = 32'h3F68F5C3;
    vecs[1].w = '0; vecs[1].w[2] = 32'h3F000000; vecs[1].w[7] = 32'h3F000000;
    vecs[1].ack_dly = 2; vecs[1].idx = 4'd2; vecs[1].prob = 32'h3F000000;
    vecs[2].w = '0; vecs[2].w[0] = 32'h7FC00000; vecs[2].w[1] = 32'hBF800000;
    vecs[2].w[3] = 32'h7F800000; vecs[2].w[4] = 32'h80000000;
    vecs[2].ack_dly = 0; vecs[2].idx = 4'd3; vecs[2].prob = 32'h7F800000;
    vecs[3].w = {N{32'hBF800000}}; vecs[3].w[0] = 32'hFFC00000; vecs[3].w[8] = 32'hBF000000;
    vecs[3].ack_dly = 1; vecs[3].idx = 4'd8; vecs[3].prob = 32'hBF000000;
    for (int i = 0; i < N; i++) vecs[4].w[i] = 32'h3F800000 + 32'(i);
    vecs[4].ack_dly = 3; vecs[4].idx = 4'd9; vecs[4].prob = 32'h3F800009;
    vecs[5].w = {N{32'h40000000}};
    vecs[5].ack_dly = 1; vecs[5].idx = 4'd0; vecs[5].prob = 32'h40000000;

    cv[0]  = '{32'h00000000, 32'h80000000, 1'b0};
    cv[1]  = '{32'h80000000, 32'h00000000, 1'b0};
    cv[2]  = '{32'h3F800000, 32'hBF800000, 1'b1};
    cv[3]  = '{32'hBF800000, 32'h3F800000, 1'b0};
    cv[4]  = '{32'hBF800000, 32'hC0000000, 1'b1};
    cv[5]  = '{32'hC0000000, 32'hBF800000, 1'b0};
    cv[6]  = '{32'h7F800000, 32'h3F800000, 1'b1};
    cv[7]  = '{32'h7FC00000, 32'hFF800000, 1'b0};
    cv[8]  = '{32'hFF800000, 32'h7FC00000, 1'b1};
    cv[9]  = '{32'h7FC00000, 32'hFFC00001, 1'b0};
    cv[10] = '{32'h40000000, 32'h3F800000, 1'b1};
    cv[11] = '{32'h00000000, 32'hBF800000, 1'b1};

    // reset state
    #12;
    check("rst_enb", 32'(soft_enb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_idx", 32'(res_idx), 32'd0);
    check("rst_prob", res_prob, 32'd0);
    check("rst_timeout", 32'(res_timeout), 32'd0);
    @(negedge clk) rst = 1'b0;

    // float compare unit
    for (int i = 0; i < 12; i++) begin
      ca = cv[i].a;
      cb = cv[i].b;
      #1;
      check($sformatf("cmp%0d", i), 32'(cgt), 32'(cv[i].gt));
    end

    // table-driven classifications
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

    // backpressure: 20 cycles with res_ready low and start pulsed, then next start accepted
    run_vec(vecs[1], "bp", 20);
    run_vec(vecs[4], "bp_next", 0);

    // no ack: timeout after TO cycles of soft_enb
    sbq.push_back('{idx: '0, prob: '0, to: 1'b1});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (soft_enb && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("to_enb_cycles", 32'(k), 32'(TO));
    check("to_valid", 32'(res_valid), 32'd1);
    pop_check("to", e);
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    run_vec(vecs[2], "after_to", 0);

    // async reset while waiting for ack: soft_enb drops at once
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rstw_enb", 32'(soft_enb), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // async reset mid-SCAN, after a result with a nonzero index
    run_vec(vecs[0], "pre_rst", 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    soft_ack = 1'b1; soft_data = vecs[4].w;
    @(posedge clk); #1 soft_ack = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rsts_enb", 32'(soft_enb), 32'd0);
    check("rsts_busy", 32'(busy), 32'd0);
    check("rsts_valid", 32'(res_valid), 32'd0);
    check("rsts_idx", 32'(res_idx), 32'd0);
    check("rsts_prob", res_prob, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_vec(vecs[0], "post_rst", 0);

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
